// File: rtl/id_ex_issue_stage_pkg.sv
// Shared types and constants for the decode/issue stage.
// EXE codes, opcode/funct values and the ID/EX register bundle.
package id_ex_issue_stage_pkg;

    localparam int WORD_LEN     = 32;
    localparam int EXE_CMD_LEN  = 4;
    localparam int REG_ADDR_LEN = 5;

    typedef logic [WORD_LEN-1:0]     word_t;
    typedef logic [EXE_CMD_LEN-1:0]  exe_cmd_t;
    typedef logic [REG_ADDR_LEN-1:0] reg_addr_t;

    localparam exe_cmd_t EXE_NOP = 4'd0;
    localparam exe_cmd_t EXE_ADD = 4'd1;
    localparam exe_cmd_t EXE_SUB = 4'd2;
    localparam exe_cmd_t EXE_AND = 4'd3;
    localparam exe_cmd_t EXE_OR  = 4'd4;
    localparam exe_cmd_t EXE_XOR = 4'd5;
    localparam exe_cmd_t EXE_SLT = 4'd6;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_XORI  = 6'h0E;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;

    typedef enum logic [1:0] {
        DEST_NONE = 2'd0,
        DEST_RT   = 2'd1,
        DEST_RD   = 2'd2
    } dest_sel_e;

    typedef struct packed {
        exe_cmd_t  cmd;
        logic      imm_sel;
        logic      zext;
        dest_sel_e dest_sel;
        logic      mem_rd;
        logic      mem_wr;
        logic      branch;
        logic      reads_rt;
        logic      illegal;
    } dec_t;

    typedef struct packed {
        logic      valid;
        exe_cmd_t  cmd;
        word_t     bus_a;
        word_t     bus_b;
        word_t     store;
        reg_addr_t dest;
        logic      reg_write;
        logic      mem_read;
        logic      mem_write;
        logic      branch;
        logic      illegal;
        word_t     br_target;
    } id_ex_t;

    function automatic word_t branch_target(input word_t pc,
                                            input logic [15:0] imm);
        return pc + 32'd4 + {{14{imm[15]}}, imm, 2'b00};
    endfunction

endpackage

// File: rtl/id_ex_issue_stage_if.sv
// ID/EX to EX bundle: registered decode results out, ALU Zero back.
// The issue stage is the master; the EX stage is the slave.
interface id_ex_issue_stage_if;
    import id_ex_issue_stage_pkg::*;

    logic      ex_valid;
    exe_cmd_t  ex_cmd;
    word_t     ex_bus_a;
    word_t     ex_bus_b;
    word_t     ex_store;
    reg_addr_t ex_dest;
    logic      ex_reg_write;
    logic      ex_mem_read;
    logic      ex_mem_write;
    logic      ex_illegal;
    word_t     br_target;
    logic      ex_zero;

    modport master (
        output ex_valid, ex_cmd, ex_bus_a, ex_bus_b, ex_store,
        output ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
        output ex_illegal, br_target,
        input  ex_zero
    );

    modport slave (
        input  ex_valid, ex_cmd, ex_bus_a, ex_bus_b, ex_store,
        input  ex_dest, ex_reg_write, ex_mem_read, ex_mem_write,
        input  ex_illegal, br_target,
        output ex_zero
    );

endinterface

// File: rtl/id_ex_issue_stage_instr_decoder.sv
// Combinational opcode/funct decoder for the issue stage.
// Anything outside the supported subset decodes as illegal.
module id_ex_issue_stage_instr_decoder
    import id_ex_issue_stage_pkg::*;
(
    input  logic [5:0] op_i,
    input  logic [5:0] funct_i,
    output dec_t       dec_o
);

    always_comb begin
        dec_o = '0;
        unique case (1'b1)
            (op_i == OP_RTYPE): begin
                dec_o.dest_sel = DEST_RD;
                dec_o.reads_rt = 1'b1;
                unique case (1'b1)
                    (funct_i == FN_ADD): dec_o.cmd = EXE_ADD;
                    (funct_i == FN_SUB): dec_o.cmd = EXE_SUB;
                    (funct_i == FN_AND): dec_o.cmd = EXE_AND;
                    (funct_i == FN_OR):  dec_o.cmd = EXE_OR;
                    (funct_i == FN_XOR): dec_o.cmd = EXE_XOR;
                    (funct_i == FN_SLT): dec_o.cmd = EXE_SLT;
                    default: begin
                        dec_o = '0;
                        dec_o.illegal = 1'b1;
                    end
                endcase
            end
            (op_i == OP_ADDI): begin
                dec_o.cmd      = EXE_ADD;
                dec_o.imm_sel  = 1'b1;
                dec_o.dest_sel = DEST_RT;
            end
            (op_i == OP_SLTI): begin
                dec_o.cmd      = EXE_SLT;
                dec_o.imm_sel  = 1'b1;
                dec_o.dest_sel = DEST_RT;
            end
            (op_i == OP_ANDI): begin
                dec_o.cmd      = EXE_AND;
                dec_o.imm_sel  = 1'b1;
                dec_o.zext     = 1'b1;
                dec_o.dest_sel = DEST_RT;
            end
            (op_i == OP_ORI): begin
                dec_o.cmd      = EXE_OR;
                dec_o.imm_sel  = 1'b1;
                dec_o.zext     = 1'b1;
                dec_o.dest_sel = DEST_RT;
            end
            (op_i == OP_XORI): begin
                dec_o.cmd      = EXE_XOR;
                dec_o.imm_sel  = 1'b1;
                dec_o.zext     = 1'b1;
                dec_o.dest_sel = DEST_RT;
            end
            (op_i == OP_LW): begin
                dec_o.cmd      = EXE_ADD;
                dec_o.imm_sel  = 1'b1;
                dec_o.mem_rd   = 1'b1;
                dec_o.dest_sel = DEST_RT;
            end
            (op_i == OP_SW): begin
                dec_o.cmd      = EXE_ADD;
                dec_o.imm_sel  = 1'b1;
                dec_o.mem_wr   = 1'b1;
                dec_o.reads_rt = 1'b1;
            end
            (op_i == OP_BEQ): begin
                dec_o.cmd      = EXE_SUB;
                dec_o.branch   = 1'b1;
                dec_o.reads_rt = 1'b1;
            end
            default: begin
                dec_o.illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/id_ex_issue_stage.sv
// Decode stage plus ID/EX register: load-use stall and beq flush.
// Flush wins over stall; both load a bubble into ID/EX.
module id_ex_issue_stage
    import id_ex_issue_stage_pkg::*;
(
    input  logic      clk,
    input  logic      rst,
    input  logic      if_valid_i,
    input  word_t     if_instr_i,
    input  word_t     if_pc_i,
    output reg_addr_t rf_rs_addr_o,
    output reg_addr_t rf_rt_addr_o,
    input  word_t     rf_rd1_i,
    input  word_t     rf_rd2_i,
    output logic      flush_o,
    output logic      stall_o,
    id_ex_issue_stage_if.master ex
);

    id_ex_t    ex_q;
    id_ex_t    ex_d;
    dec_t      dec;
    reg_addr_t rs;
    reg_addr_t rt;
    reg_addr_t rd;
    reg_addr_t dest_w;
    logic [15:0] imm;
    word_t     ext_imm;
    logic      hit;
    logic      unused_shamt;

    assign rs  = if_instr_i[25:21];
    assign rt  = if_instr_i[20:16];
    assign rd  = if_instr_i[15:11];
    assign imm = if_instr_i[15:0];
    assign unused_shamt = ^if_instr_i[10:6];

    assign rf_rs_addr_o = rs;
    assign rf_rt_addr_o = rt;

    id_ex_issue_stage_instr_decoder u_dec (
        .op_i    (if_instr_i[31:26]),
        .funct_i (if_instr_i[5:0]),
        .dec_o   (dec)
    );

    assign ext_imm = dec.zext ? {16'b0, imm}
                              : {{16{imm[15]}}, imm};

    always_comb begin
        dest_w = '0;
        unique case (dec.dest_sel)
            DEST_RT: dest_w = rt;
            DEST_RD: dest_w = rd;
            default: dest_w = '0;
        endcase
    end

    assign flush_o = ex_q.valid & ex_q.branch & ex.ex_zero;

    assign hit = (ex_q.dest == rs)
               | ((ex_q.dest == rt) & dec.reads_rt);

    assign stall_o = ex_q.valid & ex_q.mem_read & if_valid_i
                   & hit & (ex_q.dest != '0) & ~flush_o;

    always_comb begin
        ex_d = '0;
        if (if_valid_i && !flush_o && !stall_o) begin
            if (dec.illegal) begin
                ex_d.illegal = 1'b1;
            end else begin
                ex_d.valid     = 1'b1;
                ex_d.cmd       = dec.cmd;
                ex_d.bus_a     = rf_rd1_i;
                ex_d.bus_b     = dec.imm_sel ? ext_imm : rf_rd2_i;
                ex_d.store     = rf_rd2_i;
                ex_d.dest      = dest_w;
                ex_d.reg_write = (dest_w != '0);
                ex_d.mem_read  = dec.mem_rd;
                ex_d.mem_write = dec.mem_wr;
                ex_d.branch    = dec.branch;
                ex_d.br_target = dec.branch
                               ? branch_target(if_pc_i, imm)
                               : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q <= '0;
        end else begin
            ex_q <= ex_d;
        end
    end

    assign ex.ex_valid     = ex_q.valid;
    assign ex.ex_cmd       = ex_q.cmd;
    assign ex.ex_bus_a     = ex_q.bus_a;
    assign ex.ex_bus_b     = ex_q.bus_b;
    assign ex.ex_store     = ex_q.store;
    assign ex.ex_dest      = ex_q.dest;
    assign ex.ex_reg_write = ex_q.reg_write;
    assign ex.ex_mem_read  = ex_q.mem_read;
    assign ex.ex_mem_write = ex_q.mem_write;
    assign ex.ex_illegal   = ex_q.illegal;
    assign ex.br_target    = ex_q.br_target;

endmodule

// File: tb/tb_id_ex_issue_stage.sv
// Testbench for id_ex_issue_stage: directed scenarios plus a
// randomized run against a table-driven reference model.
module tb_id_ex_issue_stage;
    import id_ex_issue_stage_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        if_valid;
    logic [31:0] if_instr;
    logic [31:0] if_pc;
    logic [31:0] rd1;
    logic [31:0] rd2;
    logic [4:0]  rs_a;
    logic [4:0]  rt_a;
    logic        flush;
    logic        stall;
    int          tests = 0;
    int          fails = 0;

    always #5 clk = ~clk;

    id_ex_issue_stage_if exb ();

    id_ex_issue_stage dut (
        .clk          (clk),
        .rst          (rst),
        .if_valid_i   (if_valid),
        .if_instr_i   (if_instr),
        .if_pc_i      (if_pc),
        .rf_rs_addr_o (rs_a),
        .rf_rt_addr_o (rt_a),
        .rf_rd1_i     (rd1),
        .rf_rd2_i     (rd2),
        .flush_o      (flush),
        .stall_o      (stall),
        .ex           (exb)
    );

    typedef struct {
        logic        v;
        logic [3:0]  cmd;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] st;
        logic [4:0]  dest;
        logic        rw;
        logic        ld;
        logic        sw;
        logic        br;
        logic        ill;
        logic [31:0] tgt;
    } mstate_t;

    function automatic logic [31:0] r_ins(input logic [5:0] f,
        input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
        return {6'h00, s, t, d, 5'd0, f};
    endfunction

    function automatic logic [31:0] i_ins(input logic [5:0] op,
        input logic [4:0] s, input logic [4:0] t, input logic [15:0] im);
        return {op, s, t, im};
    endfunction

    // dst: 0 none, 1 rt, 2 rd
    function automatic void ref_dec(input logic [31:0] ins,
        output logic ill, output logic [3:0] cmd, output logic uimm,
        output logic zx, output int dst, output logic ld,
        output logic st, output logic br, output logic rrt);
        logic [5:0] op;
        logic [5:0] fn;
        op = ins[31:26];
        fn = ins[5:0];
        ill = 0; cmd = 0; uimm = 0; zx = 0; dst = 0;
        ld = 0; st = 0; br = 0; rrt = 0;
        case (op)
            6'h00: begin
                dst = 2; rrt = 1;
                case (fn)
                    6'h20: cmd = EXE_ADD;
                    6'h22: cmd = EXE_SUB;
                    6'h24: cmd = EXE_AND;
                    6'h25: cmd = EXE_OR;
                    6'h26: cmd = EXE_XOR;
                    6'h2A: cmd = EXE_SLT;
                    default: ill = 1;
                endcase
            end
            6'h08: begin cmd = EXE_ADD; uimm = 1; dst = 1; end
            6'h0A: begin cmd = EXE_SLT; uimm = 1; dst = 1; end
            6'h0C: begin cmd = EXE_AND; uimm = 1; zx = 1; dst = 1; end
            6'h0D: begin cmd = EXE_OR;  uimm = 1; zx = 1; dst = 1; end
            6'h0E: begin cmd = EXE_XOR; uimm = 1; zx = 1; dst = 1; end
            6'h23: begin cmd = EXE_ADD; uimm = 1; ld = 1; dst = 1; end
            6'h2B: begin cmd = EXE_ADD; uimm = 1; st = 1; rrt = 1; end
            6'h04: begin cmd = EXE_SUB; br = 1; rrt = 1; end
            default: ill = 1;
        endcase
        if (ill) begin
            cmd = 0; uimm = 0; zx = 0; dst = 0; rrt = 0;
        end
    endfunction

    task automatic drive(input logic v, input logic [31:0] ins,
        input logic [31:0] pc, input logic [31:0] a,
        input logic [31:0] b, input logic z);
        @(negedge clk);
        if_valid    = v;
        if_instr    = ins;
        if_pc       = pc;
        rd1         = a;
        rd2         = b;
        exb.ex_zero = z;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, r_ins(6'h20, 5'd1, 5'd2, 5'd3), 32'h40, 32'd5, 32'd7, 1'b1);
        tick();
        tick();
        tests++; if (exb.ex_valid !== 1'b0) begin fails++;
            $display("FAIL rst_valid got %0h exp 0", exb.ex_valid); end
        tests++; if ({exb.ex_cmd, exb.ex_dest, exb.ex_reg_write,
                      exb.ex_mem_read, exb.ex_mem_write, exb.ex_illegal} !== '0) begin
            fails++; $display("FAIL rst_ctrl got cmd=%0h dest=%0d rw=%0b",
                exb.ex_cmd, exb.ex_dest, exb.ex_reg_write); end
        tests++; if ({exb.ex_bus_a, exb.ex_bus_b, exb.ex_store, exb.br_target} !== '0) begin
            fails++; $display("FAIL rst_data got a=%0h b=%0h tgt=%0h exp 0",
                exb.ex_bus_a, exb.ex_bus_b, exb.br_target); end
        tests++; if ({stall, flush} !== 2'b00) begin fails++;
            $display("FAIL rst_hazard got stall=%0b flush=%0b exp 0", stall, flush); end
        rst = 1'b0;
    endtask

    task automatic test_rtype();
        drive(1'b1, r_ins(6'h20, 5'd1, 5'd2, 5'd3), 32'h44, 32'd5, 32'd7, 1'b0);
        tests++; if ({rs_a, rt_a} !== {5'd1, 5'd2}) begin fails++;
            $display("FAIL rf_addr got rs=%0d rt=%0d exp 1 2", rs_a, rt_a); end
        tick();
        tests++; if ({exb.ex_valid, exb.ex_cmd, exb.ex_dest, exb.ex_reg_write}
                     !== {1'b1, EXE_ADD, 5'd3, 1'b1}) begin fails++;
            $display("FAIL add_ctrl got v=%0b cmd=%0h dest=%0d rw=%0b",
                exb.ex_valid, exb.ex_cmd, exb.ex_dest, exb.ex_reg_write); end
        tests++; if ({exb.ex_bus_a, exb.ex_bus_b} !== {32'd5, 32'd7}) begin fails++;
            $display("FAIL add_bus got a=%0h b=%0h exp 5 7", exb.ex_bus_a, exb.ex_bus_b); end
    endtask

    task automatic test_imm();
        drive(1'b1, i_ins(6'h0C, 5'd1, 5'd4, 16'hFFFF), 32'h48, 32'h12345678, 32'h9, 1'b0);
        tick();
        tests++; if ({exb.ex_cmd, exb.ex_bus_b, exb.ex_dest}
                     !== {EXE_AND, 32'h0000FFFF, 5'd4}) begin fails++;
            $display("FAIL andi got cmd=%0h b=%0h dest=%0d exp %0h 0000ffff 4",
                exb.ex_cmd, exb.ex_bus_b, exb.ex_dest, EXE_AND); end
        tests++; if (exb.ex_bus_a !== 32'h12345678) begin fails++;
            $display("FAIL andi_a got %0h exp 12345678", exb.ex_bus_a); end
        drive(1'b1, i_ins(6'h08, 5'd1, 5'd5, 16'hFFFF), 32'h4C, 32'h1, 32'h9, 1'b0);
        tick();
        tests++; if ({exb.ex_cmd, exb.ex_bus_b} !== {EXE_ADD, 32'hFFFFFFFF}) begin fails++;
            $display("FAIL addi got cmd=%0h b=%0h exp %0h ffffffff",
                exb.ex_cmd, exb.ex_bus_b, EXE_ADD); end
    endtask

    task automatic test_load_use();
        drive(1'b1, i_ins(6'h23, 5'd1, 5'd2, 16'h0), 32'h50, 32'h100, 32'h0, 1'b0);
        tick();
        tests++; if ({exb.ex_mem_read, exb.ex_dest, exb.ex_reg_write}
                     !== {1'b1, 5'd2, 1'b1}) begin fails++;
            $display("FAIL lw got mr=%0b dest=%0d rw=%0b", exb.ex_mem_read,
                exb.ex_dest, exb.ex_reg_write); end
        drive(1'b1, r_ins(6'h20, 5'd2, 5'd2, 5'd3), 32'h54, 32'd1, 32'd1, 1'b0);
        tests++; if (stall !== 1'b1) begin fails++;
            $display("FAIL lu_stall got %0b exp 1", stall); end
        tick();
        tests++; if ({exb.ex_valid, exb.ex_mem_read, exb.ex_reg_write} !== 3'b000) begin
            fails++; $display("FAIL lu_bubble got v=%0b mr=%0b rw=%0b",
                exb.ex_valid, exb.ex_mem_read, exb.ex_reg_write); end
        tests++; if (stall !== 1'b0) begin fails++;
            $display("FAIL lu_stall_once got %0b exp 0", stall); end
        tick();
        tests++; if ({exb.ex_valid, exb.ex_cmd, exb.ex_dest} !== {1'b1, EXE_ADD, 5'd3}) begin
            fails++; $display("FAIL lu_issue got v=%0b cmd=%0h dest=%0d",
                exb.ex_valid, exb.ex_cmd, exb.ex_dest); end
        drive(1'b1, i_ins(6'h23, 5'd1, 5'd0, 16'h0), 32'h58, 32'h100, 32'h0, 1'b0);
        tick();
        drive(1'b1, r_ins(6'h20, 5'd0, 5'd0, 5'd3), 32'h5C, 32'd0, 32'd0, 1'b0);
        tests++; if (stall !== 1'b0) begin fails++;
            $display("FAIL lw_r0_stall got %0b exp 0", stall); end
        tick();
        tests++; if (exb.ex_valid !== 1'b1) begin fails++;
            $display("FAIL lw_r0_issue got v=%0b exp 1", exb.ex_valid); end
    endtask

    task automatic test_beq();
        drive(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'd3), 32'h100, 32'd9, 32'd9, 1'b0);
        tick();
        tests++; if ({exb.br_target, exb.ex_cmd, exb.ex_reg_write, exb.ex_bus_b}
                     !== {32'h110, EXE_SUB, 1'b0, 32'd9}) begin fails++;
            $display("FAIL beq got tgt=%0h cmd=%0h rw=%0b b=%0h exp 110",
                exb.br_target, exb.ex_cmd, exb.ex_reg_write, exb.ex_bus_b); end
        drive(1'b1, r_ins(6'h20, 5'd1, 5'd1, 5'd3), 32'h104, 32'd1, 32'd1, 1'b1);
        tests++; if (flush !== 1'b1) begin fails++;
            $display("FAIL beq_flush got %0b exp 1", flush); end
        tick();
        tests++; if (exb.ex_valid !== 1'b0) begin fails++;
            $display("FAIL beq_kill got v=%0b exp 0", exb.ex_valid); end
        drive(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'h0004), 32'hFFFFFFF0, 32'd1, 32'd2, 1'b0);
        tick();
        tests++; if (exb.br_target !== 32'h00000004) begin fails++;
            $display("FAIL beq_wrap got %0h exp 4", exb.br_target); end
        drive(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'h8000), 32'h100, 32'd1, 32'd2, 1'b0);
        tests++; if (flush !== 1'b0) begin fails++;
            $display("FAIL beq_nt_flush got %0b exp 0", flush); end
        tick();
        tests++; if (exb.br_target !== 32'hFFFE0104) begin fails++;
            $display("FAIL beq_neg got %0h exp fffe0104", exb.br_target); end
        drive(1'b1, r_ins(6'h22, 5'd1, 5'd1, 5'd6), 32'h104, 32'd1, 32'd1, 1'b0);
        tick();
        tests++; if ({exb.ex_valid, exb.ex_cmd} !== {1'b1, EXE_SUB}) begin fails++;
            $display("FAIL beq_nt_issue got v=%0b cmd=%0h", exb.ex_valid, exb.ex_cmd); end
    endtask

    task automatic test_flush_illegal();
        drive(1'b1, i_ins(6'h04, 5'd1, 5'd2, 16'd1), 32'h200, 32'd4, 32'd4, 1'b0);
        tick();
        drive(1'b1, r_ins(6'h20, 5'd2, 5'd2, 5'd3), 32'h204, 32'd1, 32'd1, 1'b1);
        tests++; if ({flush, stall} !== 2'b10) begin fails++;
            $display("FAIL prio got flush=%0b stall=%0b exp 1 0", flush, stall); end
        tick();
        drive(1'b1, i_ins(6'h3F, 5'd1, 5'd2, 16'h1234), 32'h208, 32'd1, 32'd1, 1'b0);
        tick();
        tests++; if ({exb.ex_illegal, exb.ex_valid, exb.ex_cmd} !== {1'b1, 1'b0, 4'd0}) begin
            fails++; $display("FAIL illegal_op got ill=%0b v=%0b cmd=%0h",
                exb.ex_illegal, exb.ex_valid, exb.ex_cmd); end
        drive(1'b1, r_ins(6'h00, 5'd1, 5'd2, 5'd3), 32'h20C, 32'd1, 32'd1, 1'b0);
        tick();
        tests++; if ({exb.ex_illegal, exb.ex_valid} !== 2'b10) begin fails++;
            $display("FAIL illegal_fn got ill=%0b v=%0b", exb.ex_illegal, exb.ex_valid); end
        drive(1'b1, r_ins(6'h25, 5'd1, 5'd2, 5'd3), 32'h210, 32'd1, 32'd1, 1'b0);
        tick();
        tests++; if ({exb.ex_illegal, exb.ex_valid} !== 2'b01) begin fails++;
            $display("FAIL illegal_pulse got ill=%0b v=%0b", exb.ex_illegal, exb.ex_valid); end
        drive(1'b1, i_ins(6'h23, 5'd1, 5'd7, 16'h8), 32'h214, 32'd1, 32'd1, 1'b0);
        tick();
        rst = 1'b1;
        drive(1'b1, r_ins(6'h20, 5'd1, 5'd2, 5'd3), 32'h218, 32'd1, 32'd1, 1'b0);
        tick();
        rst = 1'b0;
        tests++; if ({exb.ex_valid, exb.ex_mem_read, exb.ex_dest} !== '0) begin fails++;
            $display("FAIL mid_rst got v=%0b mr=%0b dest=%0d", exb.ex_valid,
                exb.ex_mem_read, exb.ex_dest); end
    endtask

    task automatic test_random();
        logic [5:0]  fns [6] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h26, 6'h2A};
        logic [5:0]  iops [5] = '{6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E};
        logic [31:0] ins, pc, a, b, bb, tg;
        logic [4:0]  s, t, d, dd;
        logic [15:0] im;
        logic        v, z, r, ill, uimm, zx, ld, st, br, rrt, mfl, mst;
        logic [3:0]  cmd;
        int          dst, k;
        mstate_t     m, nx;
        rst = 1'b1;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0, 1'b0);
        tick();
        rst = 1'b0;
        m = '{default: '0};
        for (int i = 0; i < 400; i++) begin
            s  = 5'($urandom_range(0, 3));
            t  = 5'($urandom_range(0, 3));
            d  = 5'($urandom_range(0, 3));
            im = 16'($urandom);
            k  = $urandom_range(0, 15);
            if (k < 6)       ins = r_ins(fns[k], s, t, d);
            else if (k < 11) ins = i_ins(iops[k-6], s, t, im);
            else if (k == 11) ins = i_ins(6'h23, s, t, im);
            else if (k == 12) ins = i_ins(6'h2B, s, t, im);
            else if (k == 13) ins = i_ins(6'h04, s, t, im);
            else if (k == 14) ins = i_ins(6'h3F, s, t, im);
            else              ins = r_ins(6'h00, s, t, d);
            r  = ($urandom_range(0, 39) == 0);
            v  = ($urandom_range(0, 5) != 0);
            z  = 1'($urandom_range(0, 1));
            a  = $urandom;
            b  = $urandom;
            pc = $urandom & 32'hFFFF_FFFC;
            rst = r;
            drive(v, ins, pc, a, b, z);
            ref_dec(ins, ill, cmd, uimm, zx, dst, ld, st, br, rrt);
            mfl = m.v && m.br && z;
            mst = m.v && m.ld && v && m.dest != 0 && !mfl
                && (m.dest == s || (m.dest == t && rrt));
            tests++; if ({flush, stall} !== {mfl, mst}) begin fails++;
                $display("FAIL rnd_haz[%0d] got f=%0b s=%0b exp f=%0b s=%0b",
                    i, flush, stall, mfl, mst); end
            tests++; if ({rs_a, rt_a} !== {s, t}) begin fails++;
                $display("FAIL rnd_rf[%0d] got %0d %0d exp %0d %0d", i, rs_a, rt_a, s, t); end
            nx = '{default: '0};
            if (!r && v && !mfl && !mst) begin
                if (ill) begin
                    nx.ill = 1'b1;
                end else begin
                    bb = zx ? {16'h0, im} : 32'($signed(im));
                    dd = (dst == 1) ? t : (dst == 2) ? d : 5'd0;
                    tg = pc + 32'd4 + 32'($signed(im)) * 32'd4;
                    nx.v = 1; nx.cmd = cmd; nx.a = a;
                    nx.b = uimm ? bb : b;
                    nx.st = b; nx.dest = dd; nx.rw = (dd != 0);
                    nx.ld = ld; nx.sw = st; nx.br = br;
                    nx.tgt = br ? tg : 32'h0;
                end
            end
            m = nx;
            tick();
            tests++; if ({exb.ex_valid, exb.ex_cmd, exb.ex_illegal} !== {m.v, m.cmd, m.ill}) begin
                fails++; $display("FAIL rnd_ctl[%0d] got v=%0b c=%0h i=%0b exp v=%0b c=%0h i=%0b",
                    i, exb.ex_valid, exb.ex_cmd, exb.ex_illegal, m.v, m.cmd, m.ill); end
            tests++; if ({exb.ex_bus_a, exb.ex_bus_b, exb.ex_store} !== {m.a, m.b, m.st}) begin
                fails++; $display("FAIL rnd_bus[%0d] got %0h %0h %0h exp %0h %0h %0h", i,
                    exb.ex_bus_a, exb.ex_bus_b, exb.ex_store, m.a, m.b, m.st); end
            tests++; if ({exb.ex_dest, exb.ex_reg_write, exb.ex_mem_read, exb.ex_mem_write}
                         !== {m.dest, m.rw, m.ld, m.sw}) begin fails++;
                $display("FAIL rnd_wb[%0d] got d=%0d rw=%0b mr=%0b mw=%0b exp d=%0d rw=%0b mr=%0b mw=%0b",
                    i, exb.ex_dest, exb.ex_reg_write, exb.ex_mem_read, exb.ex_mem_write,
                    m.dest, m.rw, m.ld, m.sw); end
            tests++; if (exb.br_target !== m.tgt) begin fails++;
                $display("FAIL rnd_tgt[%0d] got %0h exp %0h", i, exb.br_target, m.tgt); end
        end
        rst = 1'b0;
    endtask

    initial begin
        rst         = 1'b0;
        if_valid    = 1'b0;
        if_instr    = '0;
        if_pc       = '0;
        rd1         = '0;
        rd2         = '0;
        exb.ex_zero = 1'b0;
        test_reset();
        test_rtype();
        test_imm();
        test_load_use();
        test_beq();
        test_flush_illegal();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

endmodule
